// File: rtl/tpg_sched_pkg.sv
// Shared types for the test-pattern frame scheduler: mode/state encodings,
// host register field positions and the active configuration record.
package tpg_sched_pkg;

  typedef enum logic [2:0] {
    STNDRT   = 3'd0,
    OFFSET   = 3'd1,
    GRAD     = 3'd2,
    ONECOLOR = 3'd3,
    IMAGE    = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_WIDTH  = 1;
  localparam int REG_HEIGHT = 2;
  localparam int REG_COLOR  = 3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BW_BIT    = 1;
  localparam int CTRL_AUTO_BIT  = 2;
  localparam int CTRL_MODE_LSB  = 4;
  localparam int CTRL_DWELL_LSB = 8;
  localparam int CTRL_IL_LSB    = 16;
  localparam int CTRL_OFF_LSB   = 24;
  localparam int COLOR_LSB      = 0;
  localparam int MASK_LSB       = 24;

  typedef struct packed {
    logic        enable;
    logic        mode_bw;
    logic        auto_cycle;
    mode_e       mode;
    logic [7:0]  dwell;
    logic [5:0]  interlaced;
    logic [7:0]  offset_frames;
    logic [31:0] width;
    logic [31:0] height;
    logic [23:0] color;
    logic [4:0]  mode_mask;
  } cfg_t;

  // Out-of-range mode selects fall back to the standard pattern.
  function automatic mode_e clamp_mode(input logic [2:0] m, input int num_modes);
    return (int'(m) < num_modes) ? mode_e'(m) : STNDRT;
  endfunction

  // A zero dimension would stall the generator, so it is committed as 1.
  function automatic logic [31:0] dim_min1(input logic [15:0] d);
    return (d == 16'd0) ? 32'd1 : {16'd0, d};
  endfunction

endpackage

// File: rtl/tpg_mode_rotator.sv
// Combinational: picks the next enabled pattern mode above the current one,
// wrapping to mode 0; o_changed low when no other mode is enabled.
module tpg_mode_rotator
  import tpg_sched_pkg::*;
#(
  parameter int NUM_MODES = 5
) (
  input  mode_e      i_mode,
  input  logic [4:0] i_mask,
  output mode_e      o_next,
  output logic       o_changed
);

  logic [3:0] w_sum;
  logic [2:0] w_idx;

  // Scan from farthest to nearest so the nearest enabled mode wins.
  always_comb begin
    o_next    = i_mode;
    o_changed = 1'b0;
    w_sum     = 4'd0;
    w_idx     = 3'd0;
    for (int k = NUM_MODES - 1; k >= 1; k--) begin
      w_sum = {1'b0, i_mode} + 4'(k);
      if (w_sum >= 4'(NUM_MODES)) w_sum = w_sum - 4'(NUM_MODES);
      w_idx = w_sum[2:0];
      if (i_mask[w_idx]) begin
        o_next    = mode_e'(w_idx);
        o_changed = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpg_frame_scheduler.sv
// Shadows host register writes and commits them to the pattern generator only at
// frame boundaries (1 cycle after the write in IDLE, 1 cycle after fb otherwise); optional auto mode rotation.
module tpg_frame_scheduler
  import tpg_sched_pkg::*;
#(
  parameter int DW                = 32,
  parameter int REGS_NUM          = 4,
  parameter int NUM_MODES         = 5,
  parameter int DEF_WIDTH         = 600,
  parameter int DEF_HEIGHT        = 800,
  parameter int DEF_INTERLACED    = 3,
  parameter int DEF_OFFSET_FRAMES = 25,
  parameter int DEF_MODE          = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [REGS_NUM-1:0]          word_valid_wr_i,
  input  logic [REGS_NUM-1:0][DW-1:0]  word_i,
  input  logic                         end_of_video_i,
  input  logic                         valid_i,
  input  logic                         ready_i,
  output logic                         enable_o,
  output logic [2:0]                   mode_o,
  output logic                         mode_bw_o,
  output logic [31:0]                  width_o,
  output logic [31:0]                  height_o,
  output logic [5:0]                   interlaced_o,
  output logic [7:0]                   offset_frames_o,
  output logic [23:0]                  color_onecolor_o,
  output logic [DW-1:0]                status_o
);

  localparam logic [31:0] C_SH_CTRL_RST = {8'(DEF_OFFSET_FRAMES), 2'b00, 6'(DEF_INTERLACED),
                                           8'd0, 1'b0, 3'(DEF_MODE), 4'd0};
  localparam logic [31:0] C_SH_WIDTH_RST  = 32'(DEF_WIDTH);
  localparam logic [31:0] C_SH_HEIGHT_RST = 32'(DEF_HEIGHT);

  localparam cfg_t C_CFG_RST = '{
    enable:        1'b0,
    mode_bw:       1'b0,
    auto_cycle:    1'b0,
    mode:          mode_e'(3'(DEF_MODE)),
    dwell:         8'd0,
    interlaced:    6'(DEF_INTERLACED),
    offset_frames: 8'(DEF_OFFSET_FRAMES),
    width:         32'(DEF_WIDTH),
    height:        32'(DEF_HEIGHT),
    color:         24'd0,
    mode_mask:     5'd0
  };

  state_e                       r_state;
  cfg_t                         r_cfg;
  logic [REGS_NUM-1:0][DW-1:0]  r_shadow;
  logic [15:0]                  r_frame_cnt;
  logic [7:0]                   r_dwell_cnt;

  logic [REGS_NUM-1:0][DW-1:0]  w_fwd;
  cfg_t                         w_new_cfg;
  logic                         w_fb;
  logic                         w_wr_any;
  logic [8:0]                   w_dwell_nxt;
  logic [8:0]                   w_dwell_lim;
  mode_e                        w_next_mode;
  logic                         w_mode_changed;
  logic                         w_unused_fwd;

  assign w_fb        = end_of_video_i & valid_i & ready_i;
  assign w_wr_any    = |word_valid_wr_i;
  assign w_dwell_nxt = {1'b0, r_dwell_cnt} + 9'd1;
  assign w_dwell_lim = (r_cfg.dwell == 8'd0) ? 9'd1 : {1'b0, r_cfg.dwell};

  // Write strobes are forwarded so a write landing on the commit cycle is not lost.
  always_comb begin
    w_fwd = r_shadow;
    for (int i = 0; i < REGS_NUM; i++) begin
      if (word_valid_wr_i[i]) w_fwd[i] = word_i[i];
    end
    w_new_cfg               = C_CFG_RST;
    w_new_cfg.enable        = w_fwd[REG_CTRL][CTRL_EN_BIT];
    w_new_cfg.mode_bw       = w_fwd[REG_CTRL][CTRL_BW_BIT];
    w_new_cfg.auto_cycle    = w_fwd[REG_CTRL][CTRL_AUTO_BIT];
    w_new_cfg.mode          = clamp_mode(w_fwd[REG_CTRL][CTRL_MODE_LSB +: 3], NUM_MODES);
    w_new_cfg.dwell         = w_fwd[REG_CTRL][CTRL_DWELL_LSB +: 8];
    w_new_cfg.interlaced    = w_fwd[REG_CTRL][CTRL_IL_LSB +: 6];
    w_new_cfg.offset_frames = w_fwd[REG_CTRL][CTRL_OFF_LSB +: 8];
    w_new_cfg.width         = dim_min1(w_fwd[REG_WIDTH][15:0]);
    w_new_cfg.height        = dim_min1(w_fwd[REG_HEIGHT][15:0]);
    w_new_cfg.color         = w_fwd[REG_COLOR][COLOR_LSB +: 24];
    w_new_cfg.mode_mask     = w_fwd[REG_COLOR][MASK_LSB +: 5];
  end

  assign w_unused_fwd = ^w_fwd;

  tpg_mode_rotator #(
    .NUM_MODES (NUM_MODES)
  ) u_rotator (
    .i_mode    (r_cfg.mode),
    .i_mask    (r_cfg.mode_mask),
    .o_next    (w_next_mode),
    .o_changed (w_mode_changed)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state              <= IDLE;
      r_cfg                <= C_CFG_RST;
      r_shadow             <= '0;
      r_shadow[REG_CTRL]   <= C_SH_CTRL_RST;
      r_shadow[REG_WIDTH]  <= C_SH_WIDTH_RST;
      r_shadow[REG_HEIGHT] <= C_SH_HEIGHT_RST;
      r_frame_cnt          <= '0;
      r_dwell_cnt          <= '0;
    end else begin
      for (int i = 0; i < REGS_NUM; i++) begin
        if (word_valid_wr_i[i]) r_shadow[i] <= word_i[i];
      end
      if (w_fb) r_frame_cnt <= r_frame_cnt + 16'd1;

      case (r_state)
        IDLE: begin
          if (w_wr_any) begin
            r_cfg       <= w_new_cfg;
            r_dwell_cnt <= '0;
            r_state     <= w_new_cfg.enable ? RUN : IDLE;
          end
        end
        RUN: begin
          // A fresh write outranks auto rotation even when it lands on fb.
          if (w_wr_any) begin
            r_state <= PEND;
          end else if (w_fb && r_cfg.auto_cycle) begin
            if (w_dwell_nxt >= w_dwell_lim) begin
              r_dwell_cnt <= '0;
              if (w_mode_changed) r_cfg.mode <= w_next_mode;
            end else begin
              r_dwell_cnt <= w_dwell_nxt[7:0];
            end
          end
        end
        PEND: begin
          if (w_fb) begin
            r_cfg       <= w_new_cfg;
            r_dwell_cnt <= '0;
            r_state     <= w_new_cfg.enable ? RUN : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign enable_o         = r_cfg.enable;
  assign mode_o           = r_cfg.mode;
  assign mode_bw_o        = r_cfg.mode_bw;
  assign width_o          = r_cfg.width;
  assign height_o         = r_cfg.height;
  assign interlaced_o     = r_cfg.interlaced;
  assign offset_frames_o  = r_cfg.offset_frames;
  assign color_onecolor_o = r_cfg.color;

  always_comb begin
    status_o        = '0;
    status_o[2:0]   = r_cfg.mode;
    status_o[3]     = (r_state == PEND);
    status_o[5:4]   = r_state;
    status_o[31:16] = r_frame_cnt;
  end

endmodule
